// File: rtl/fpmul_rr_arbiter.sv
// Round-robin arbiter sharing one 11-bit FP multiplier among NREQ requesters.
// Optional macro FPMUL_ARB_ZERO_BYPASS_EN: operations with a +0 operand skip the multiplier.
module fpmul_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 4,
    localparam int ID_W   = $clog2(NREQ)
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*11-1:0]   req_a,
    input  logic [NREQ*11-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [10:0]          rsp_product,
    output logic                 busy,
    output logic                 mul_in_ready,
    output logic [10:0]          mul_a,
    output logic [10:0]          mul_b,
    input  logic [10:0]          mul_product,
    output logic [1:0]           dbg_state
);

    // Handshake: req_valid is a level held by the requester until its one-cycle
    // req_ready pulse; operands are captured on that same cycle. rsp_valid is a
    // one-cycle pulse with no back-pressure.

    localparam int CNT_W = $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   id_q;
    logic [CNT_W-1:0]  lat_cnt;

    logic              grant_hit;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W:0]     probe_sum;
    logic [ID_W-1:0]   probe;
    logic [10:0]       sel_a, sel_b;
    logic              last_lat;

    // Scan requesters starting at rr_ptr, wrapping modulo NREQ.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        probe_sum = '0;
        probe     = '0;
        for (int k = 0; k < NREQ; k++) begin
            probe_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (probe_sum >= (ID_W+1)'(NREQ))
                probe_sum = probe_sum - (ID_W+1)'(NREQ);
            probe = probe_sum[ID_W-1:0];
            if (!grant_hit && req_valid[probe]) begin
                grant_hit = 1'b1;
                grant_idx = probe;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_a = req_a[11*i +: 11];
                sel_b = req_b[11*i +: 11];
            end
        end
    end

`ifdef FPMUL_ARB_ZERO_BYPASS_EN
    // Only positive zero is bypassed; 11'h400 still goes through the multiplier.
    logic zero_op;
    assign zero_op = (sel_a == 11'h000) || (sel_b == 11'h000);
`endif

    assign last_lat = (lat_cnt == CNT_W'(MUL_LAT - 1));

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        case (state_q)
            ST_IDLE: begin
                if (grant_hit && !wb_rst_i) begin
                    req_ready[grant_idx] = 1'b1;
`ifdef FPMUL_ARB_ZERO_BYPASS_EN
                    state_d = zero_op ? ST_RESP : ST_ISSUE;
`else
                    state_d = ST_ISSUE;
`endif
                end
            end
            ST_ISSUE: begin
                if (last_lat)
                    state_d = ST_RESP;
            end
            ST_RESP: begin
                if (!wb_rst_i)
                    rsp_valid[id_q] = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            rr_ptr      <= '0;
            id_q        <= '0;
            lat_cnt     <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            rsp_product <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (grant_hit) begin
                        mul_a   <= sel_a;
                        mul_b   <= sel_b;
                        id_q    <= grant_idx;
                        lat_cnt <= '0;
                        rr_ptr  <= (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
`ifdef FPMUL_ARB_ZERO_BYPASS_EN
                        if (zero_op)
                            rsp_product <= 11'h000;
`endif
                    end
                end
                ST_ISSUE: begin
                    lat_cnt <= lat_cnt + 1'b1;
                    if (last_lat)
                        rsp_product <= mul_product;
                end
                default: ;
            endcase
        end
    end

    assign rsp_id       = id_q;
    assign busy         = (state_q != ST_IDLE);
    assign mul_in_ready = (state_q == ST_ISSUE);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_fpmul_rr_arbiter.sv
// Directed bench for fpmul_rr_arbiter with a behavioural multiplier that only
// presents a valid product in the last mul_in_ready cycle.
module tb_fpmul_rr_arbiter;

    localparam int NREQ    = 4;
    localparam int MUL_LAT = 4;
    localparam int ID_W    = 2;

    logic                wb_clk_i = 1'b0;
    logic                wb_rst_i = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*11-1:0]  req_a = '0;
    logic [NREQ*11-1:0]  req_b = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     rsp_valid;
    logic [ID_W-1:0]     rsp_id;
    logic [10:0]         rsp_product;
    logic                busy;
    logic                mul_in_ready;
    logic [10:0]         mul_a, mul_b;
    logic [10:0]         mul_product;
    logic [1:0]          dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int mi_cnt = 0;

    fpmul_rr_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_product  (rsp_product),
        .busy         (busy),
        .mul_in_ready (mul_in_ready),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_product  (mul_product),
        .dbg_state    (dbg_state)
    );

    // clock / reset block
    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    // Truncating FP multiply; exp 0 treated as zero, overflow saturates to {s,63,0}.
    function automatic logic [10:0] fp_mul(input logic [10:0] a, input logic [10:0] b);
        logic       s;
        logic [9:0] p;
        logic [3:0] m;
        int         e;
        s = a[10] ^ b[10];
        if (a[9:4] == 6'd0 || b[9:4] == 6'd0) return {s, 10'd0};
        p = {5'd0, 1'b1, a[3:0]} * {5'd0, 1'b1, b[3:0]};
        e = int'(a[9:4]) + int'(b[9:4]) - 31;
        if (p[9]) begin
            m = p[8:5];
            e = e + 1;
        end else begin
            m = p[7:4];
        end
        if (e >= 63) return {s, 6'h3F, 4'h0};
        if (e <= 0)  return {s, 10'd0};
        return {s, e[5:0], m};
    endfunction

    always @(posedge wb_clk_i) mi_cnt <= mul_in_ready ? mi_cnt + 1 : 0;
    assign mul_product = (mul_in_ready && mi_cnt == MUL_LAT - 1) ? fp_mul(mul_a, mul_b) : 11'h555;

    // driver tasks
    task automatic tick;
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [10:0] a, input logic [10:0] b);
        req_a[11*i +: 11] = a;
        req_b[11*i +: 11] = b;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_grant(output int cyc);
        cyc = 0;
        while (req_ready == '0 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("grant_seen", 32'(|req_ready), 32'd1);
    endtask

    task automatic do_reset;
        wb_rst_i = 1'b1;
        tick();
        tick();
        wb_rst_i = 1'b0;
    endtask

    logic [10:0] tab_a [4] = '{11'h1F0, 11'h1F8, 11'h200, 11'h3E0};
    logic [10:0] tab_b [4] = '{11'h1F8, 11'h1F8, 11'h5F4, 11'h1F0};
    logic [10:0] tab_p [4] = '{11'h1F8, 11'h202, 11'h604, 11'h3E0};

    initial begin
        int cyc;
        int gap;
        logic [NREQ-1:0] exp_g;
        logic saw_g1, saw_r1, saw_r0;

        // 1: reset with all requests pending
        req_valid = 4'hF;
        for (int i = 0; i < NREQ; i++) set_ops(i, tab_a[i], tab_b[i]);
        wb_rst_i = 1'b1;
        tick();
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mul_in_ready", 32'(mul_in_ready), 32'd0);
        check("rst_mul_ab", {10'd0, mul_a, mul_b}, 32'd0);
        check("rst_rsp", {19'd0, rsp_id, rsp_product}, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        req_valid = '0;
        wb_rst_i = 1'b0;
        tick();

        // 2: single op from requester 2
        set_ops(2, 11'h3E0, 11'h3E0);
        req_valid = 4'b0100;
        #1;
        check("single_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        set_ops(2, 11'h123, 11'h321);
        check("single_mul_a", 32'(mul_a), 32'h3E0);
        check("single_mul_b", 32'(mul_b), 32'h3E0);
        for (int c = 1; c <= MUL_LAT; c++) begin
            check("single_in_ready", 32'(mul_in_ready), 32'd1);
            check("single_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        check("single_rsp_valid", 32'(rsp_valid), 32'h4);
        check("single_rsp_id", 32'(rsp_id), 32'd2);
        check("single_product", 32'(rsp_product), 32'h3F0);
        check("single_in_ready_off", 32'(mul_in_ready), 32'd0);
        tick();
        check("single_idle_rsp", 32'(rsp_valid), 32'd0);
        check("single_idle_busy", 32'(busy), 32'd0);

        // 3: fairness with all requesters active
        do_reset();
        for (int i = 0; i < NREQ; i++) set_ops(i, tab_a[i], tab_b[i]);
        req_valid = 4'hF;
        #1;
        for (int g = 0; g < 5; g++) begin
            wait_grant(cyc);
            gap = 5 + cyc;
            if (g > 0) check("fair_gap", 32'(gap), 32'(MUL_LAT + 2));
            exp_g = 4'b0001 << (g % 4);
            check("fair_grant", 32'(req_ready), 32'(exp_g));
            for (int c = 1; c <= MUL_LAT + 1; c++) tick();
            check("fair_rsp_valid", 32'(rsp_valid), 32'(exp_g));
            check("fair_rsp_id", 32'(rsp_id), 32'(g % 4));
            check("fair_product", 32'(rsp_product), 32'(tab_p[g % 4]));
        end
        req_valid = '0;
        tick();

        // 4: reset mid-ISSUE
        do_reset();
        req_valid = 4'b0100;
        #1;
        wait_grant(cyc);
        tick();
        req_valid = 4'hF;
        tick();
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i = 1'b0;
        check("midrst_state", 32'(dbg_state), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_mul_in_ready", 32'(mul_in_ready), 32'd0);
        #1;
        check("midrst_next_grant", 32'(req_ready), 32'h1);
        tick();
        tick();
        tick();
        check("midrst_no_old_rsp", 32'(rsp_valid), 32'd0);
        req_valid = '0;
        tick();
        tick();
        check("midrst_new_rsp", 32'(rsp_valid), 32'h1);
        check("midrst_new_product", 32'(rsp_product), 32'h1F8);
        tick();

        // 5: zero and negative-zero operands
        do_reset();
        set_ops(0, 11'h000, 11'h3E0);
        req_valid = 4'b0001;
        #1;
        wait_grant(cyc);
        tick();
        req_valid = '0;
        check("zero_mul_a", 32'(mul_a), 32'h000);
        check("zero_mul_b", 32'(mul_b), 32'h3E0);
`ifdef FPMUL_ARB_ZERO_BYPASS_EN
        check("zero_bypass_rsp", 32'(rsp_valid), 32'h1);
        check("zero_bypass_in_ready", 32'(mul_in_ready), 32'd0);
        check("zero_bypass_product", 32'(rsp_product), 32'h000);
        tick();
`else
        check("zero_in_ready", 32'(mul_in_ready), 32'd1);
        for (int c = 1; c <= MUL_LAT; c++) tick();
        check("zero_rsp", 32'(rsp_valid), 32'h1);
        check("zero_product", 32'(rsp_product), 32'h000);
        tick();
`endif
        set_ops(1, 11'h400, 11'h3E0);
        req_valid = 4'b0010;
        #1;
        wait_grant(cyc);
        tick();
        req_valid = '0;
        check("negzero_in_ready", 32'(mul_in_ready), 32'd1);
        for (int c = 1; c <= MUL_LAT; c++) tick();
        check("negzero_rsp", 32'(rsp_valid), 32'h2);
        check("negzero_product", 32'(rsp_product), 32'h400);
        tick();

        // 6: request withdrawn while busy
        do_reset();
        set_ops(0, 11'h1F0, 11'h1F8);
        req_valid = 4'b0001;
        #1;
        wait_grant(cyc);
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        saw_g1 = 1'b0;
        saw_r1 = 1'b0;
        saw_r0 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (req_ready[1]) saw_g1 = 1'b1;
            if (rsp_valid[1]) saw_r1 = 1'b1;
            if (rsp_valid[0]) saw_r0 = 1'b1;
            tick();
        end
        check("withdraw_no_grant", 32'(saw_g1), 32'd0);
        check("withdraw_no_rsp", 32'(saw_r1), 32'd0);
        check("withdraw_req0_rsp", 32'(saw_r0), 32'd1);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
